// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem request/ack handshake and IF/ID register in one block.
// Optional IF_MISALIGN_CHECK_EN adds inst_misalign_o and suppresses requests for unaligned PCs.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        fetch_stall_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        inst_misalign_o
`endif
);

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;
  logic        br_pend;
  logic [31:0] br_pend_tgt;

  logic        misalign;
  logic        fetch_ok;
  logic        advance;
  logic        bubble;
  logic        capture;
  logic        pend_set;
  logic [31:0] adv_inst;
  logic [31:0] adv_pc;
  logic [31:0] next_pc;

`ifdef IF_MISALIGN_CHECK_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RESET;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: if (capture) state_nxt = S_HOLD;
      S_HOLD:  if (!stall_i) state_nxt = S_FETCH;
      default: state_nxt = S_RESET;
    endcase
  end

  // Output / handshake decode; a misaligned fetch counts as an immediate ack with data 0
  always_comb begin
    imem_req_o    = (state == S_FETCH) && !misalign;
    imem_addr_o   = imem_req_o ? pc : 32'h0;
    fetch_stall_o = imem_req_o && !imem_ack_i;
    fetch_ok      = (state == S_FETCH) && (misalign || imem_ack_i);
    advance       = !stall_i && (fetch_ok || (state == S_HOLD));
    bubble        = (state == S_FETCH) && !fetch_ok && !stall_i;
    capture       = fetch_ok && stall_i;
    pend_set      = branch_flag_i && !stall_i && !advance && !br_pend;
    adv_inst      = (state == S_HOLD) ? hold_inst : (misalign ? 32'h0 : imem_data_i);
    adv_pc        = (state == S_HOLD) ? hold_pc : pc;
    if (br_pend)            next_pc = br_pend_tgt;
    else if (branch_flag_i) next_pc = branch_target_address_i;
    else                    next_pc = pc + 32'd4;
  end

  // PC, hold buffer, pending-branch and IF/ID registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      hold_inst   <= 32'h0;
      hold_pc     <= 32'h0;
      br_pend     <= 1'b0;
      br_pend_tgt <= 32'h0;
      id_pc_o     <= 32'h0;
      id_inst_o   <= 32'h0;
    end else begin
      if (advance) begin
        id_inst_o <= adv_inst;
        id_pc_o   <= adv_pc;
        pc        <= next_pc;
        br_pend   <= 1'b0;
      end else begin
        if (bubble) begin
          id_inst_o <= 32'h0;
          id_pc_o   <= 32'h0;
        end
        // Branch left ID before its delay slot arrived: remember where to go afterwards
        if (pend_set) begin
          br_pend     <= 1'b1;
          br_pend_tgt <= branch_target_address_i;
        end
      end
      if (capture) begin
        hold_inst <= misalign ? 32'h0 : imem_data_i;
        hold_pc   <= pc;
      end
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          inst_misalign_o <= 1'b0;
    else if (advance) inst_misalign_o <= misalign;
    else if (bubble)  inst_misalign_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory returns its address as data, ack gated by ack_en.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_flag;
  logic [31:0] br_tgt;
  logic        req;
  logic [31:0] addr;
  logic        ack_en;
  logic        ack;
  logic [31:0] data;
  logic        fstall;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  int          n_checks;
  int          n_errors;
`ifdef IF_MISALIGN_CHECK_EN
  logic        mis;
`endif

  assign ack  = ack_en && req;
  assign data = addr;

  if_stage #(.RESET_PC(32'h0)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_i                 (stall),
    .branch_flag_i           (br_flag),
    .branch_target_address_i (br_tgt),
    .imem_req_o              (req),
    .imem_addr_o             (addr),
    .imem_ack_i              (ack),
    .imem_data_i             (data),
    .fetch_stall_o           (fstall),
    .id_pc_o                 (id_pc),
    .id_inst_o               (id_inst)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .inst_misalign_o         (mis)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; stall = 1'b0; br_flag = 1'b0; br_tgt = 32'h0; ack_en = 1'b1;
    step();
    step();
    check("rst_req", {31'h0, req}, 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_idpc", id_pc, 32'h0);
    check("rst_idinst", id_inst, 32'h0);
    rst = 1'b0;
    #1;
    check("rel_req", {31'h0, req}, 32'h0);

    // Zero-wait fetch stream
    step();
    check("first_req", {31'h0, req}, 32'h1);
    check("first_addr", addr, 32'h0);
    step();
    check("seq0_pc", id_pc, 32'h0);
    check("seq0_inst", id_inst, 32'h0);
    check("seq0_addr", addr, 32'h4);
    step();
    check("seq1_pc", id_pc, 32'h4);
    check("seq1_inst", id_inst, 32'h4);
    check("seq1_addr", addr, 32'h8);

    // Two wait states at 0x8
    ack_en = 1'b0;
    #1;
    check("ws_fstall0", {31'h0, fstall}, 32'h1);
    step();
    check("ws_fstall1", {31'h0, fstall}, 32'h1);
    check("ws_bub1_inst", id_inst, 32'h0);
    check("ws_bub1_pc", id_pc, 32'h0);
    check("ws_addr1", addr, 32'h8);
    step();
    check("ws_bub2_inst", id_inst, 32'h0);
    check("ws_addr2", addr, 32'h8);
    ack_en = 1'b1;
    #1;
    check("ws_fstall_done", {31'h0, fstall}, 32'h0);
    step();
    check("ws_pc", id_pc, 32'h8);
    check("ws_inst", id_inst, 32'h8);
    check("ws_next_addr", addr, 32'hC);

    // Ack at 0xC while stalled for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_req", {31'h0, req}, 32'h0);
      check("hold_idpc", id_pc, 32'h8);
    end
    stall = 1'b0;
    step();
    check("hold_rel_pc", id_pc, 32'hC);
    check("hold_rel_inst", id_inst, 32'hC);
    check("hold_next_addr", addr, 32'h10);

    // Zero-wait branch at 0x10 -> 0x100, delay slot 0x14
    step();
    check("br_id10", id_pc, 32'h10);
    br_flag = 1'b1; br_tgt = 32'h100;
    step();
    br_flag = 1'b0;
    check("br_id14", id_pc, 32'h14);
    check("br_addr", addr, 32'h100);
    step();
    check("br_id100", id_pc, 32'h100);

    // Branch at 0x104 -> 0x200 with delay slot 0x108 taking three wait states
    step();
    check("pb_id104", id_pc, 32'h104);
    br_flag = 1'b1; br_tgt = 32'h200; ack_en = 1'b0;
    step();
    br_flag = 1'b0;
    check("pb_bub_inst", id_inst, 32'h0);
    check("pb_bub_pc", id_pc, 32'h0);
    check("pb_addr", addr, 32'h108);
    br_flag = 1'b1; br_tgt = 32'h300;
    step();
    br_flag = 1'b0;
    check("pb_bub2", id_inst, 32'h0);
    step();
    ack_en = 1'b1;
    step();
    check("pb_slot", id_pc, 32'h108);
    check("pb_tgt_addr", addr, 32'h200);
    step();
    check("pb_tgt", id_pc, 32'h200);

    // Branch to the top word so pc wraps to 0
    br_flag = 1'b1; br_tgt = 32'hFFFF_FFFC;
    step();
    br_flag = 1'b0;
    check("wrap_addr", addr, 32'hFFFF_FFFC);
    step();
    check("wrap_id", id_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_id0", id_pc, 32'h0);
    step();
    check("wrap_id4", id_pc, 32'h4);

    // Async reset during a wait state
    ack_en = 1'b0;
    #1;
    check("ar_pre_fstall", {31'h0, fstall}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_req", {31'h0, req}, 32'h0);
    check("ar_addr", addr, 32'h0);
    check("ar_fstall", {31'h0, fstall}, 32'h0);
    check("ar_idpc", id_pc, 32'h0);
    check("ar_idinst", id_inst, 32'h0);
    step();
    rst = 1'b0; ack_en = 1'b1;
    step();
    check("ar_refetch_addr", addr, 32'h0);
    check("ar_refetch_req", {31'h0, req}, 32'h1);
    step();
    check("ar_refetch_id", id_pc, 32'h0);
    check("ar_refetch_next", addr, 32'h4);

`ifdef IF_MISALIGN_CHECK_EN
    br_flag = 1'b1; br_tgt = 32'h102;
    step();
    br_flag = 1'b0;
    check("mis_slot_flag", {31'h0, mis}, 32'h0);
    check("mis_noreq", {31'h0, req}, 32'h0);
    step();
    check("mis_flag", {31'h0, mis}, 32'h1);
    check("mis_pc", id_pc, 32'h102);
    check("mis_inst", id_inst, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage with PC register and IF/ID pipeline register merged into one block.
- Drives the instruction-memory request/ack handshake and feeds pc/inst to the decode stage.
- Consumes the decode stage's branch_flag/branch_target_address; honours the single MIPS delay slot.
- Reports memory wait states to the pipeline controller.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset release.

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
stall_i  input  1  controller hold of IF and ID (ID holding its instruction)
branch_flag_i  input  1  decode says instruction in ID redirects flow
branch_target_address_i  input  32  redirect target, valid with branch_flag_i
imem_req_o  output  1  fetch request
imem_addr_o  output  32  fetch address, stable while req high and no ack
imem_ack_i  input  1  one-cycle completion, data valid same cycle
imem_data_i  input  32  fetched instruction
fetch_stall_o  output  1  combinational: imem_req_o && !imem_ack_i
id_pc_o  output  32  IF/ID register: pc to decode
id_inst_o  output  32  IF/ID register: instruction to decode

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=S_RESET, id_pc_o=0, id_inst_o=0, imem_req_o=0, imem_addr_o=0, hold buffer=0, br_pend=0, br_pend_tgt=0; any outstanding request abandoned.
- imem_addr_o = pc whenever imem_req_o=1, else 0.
- States:
  - S_RESET: req=0. Moves to S_FETCH on the first edge after reset deasserts, so req goes high exactly one cycle after release.
  - S_FETCH: req=1. Ack may arrive the same cycle as req (zero-wait memory).
    - ack && !stall_i: advance. Stay in S_FETCH.
    - ack && stall_i: store imem_data_i and pc in the hold buffer; go to S_HOLD. IF/ID is unchanged.
    - !ack && !stall_i: IF/ID loads a bubble (id_inst_o=0, id_pc_o=0). pc is unchanged.
    - !ack && stall_i: no change.
  - S_HOLD: req=0.
    - !stall_i: advance using the hold buffer; go to S_FETCH.
    - stall_i: stay in S_HOLD.
- Advance, in a single edge:
  - id_inst_o and id_pc_o take the fetched instruction and its pc.
  - pc takes next_pc:
    - br_pend=1: br_pend_tgt.
    - else branch_flag_i=1: branch_target_address_i.
    - else pc+4, 32-bit wrap (FFFF_FFFC -> 0000_0000).
  - br_pend clears.
- Delay slot: the instruction fetched while a branch sits in ID is the delay slot and always enters IF/ID. The redirect applies to the fetch after it.
- Pending branch:
  - Trigger: an edge with branch_flag_i=1, stall_i=0 and no advance. The branch leaves ID before its delay slot is fetched.
  - Action: br_pend=1, br_pend_tgt=branch_target_address_i.
  - A later branch_flag_i while br_pend=1 does not overwrite it; a second branch cannot be in ID before the delay slot issues.
- branch_flag_i while stall_i=1 is ignored. ID still holds the branch and re-presents it at release.
- Latency: with zero-wait memory and no stalls, one instruction enters IF/ID per cycle. The first valid id_inst_o appears 2 edges after reset release.

Optional Feature:
- Macro: IF_MISALIGN_CHECK_EN.
- Defined:
  - Adds output inst_misalign_o (1 bit, reset 0), registered alongside IF/ID.
  - If pc[1:0]!=0 in S_FETCH, no request is issued; the fetch is treated as an immediate ack with data 0.
  - That slot enters IF/ID with id_inst_o=0, id_pc_o=pc and inst_misalign_o=1. Every other advance loads inst_misalign_o=0.
  - next_pc follows the normal rules.
- Undefined: no port; low address bits are passed to memory unchanged.

Test Plan:
- Reset release, ack tied high with memory returning its address as data:
  - imem_req_o rises 1 cycle after release with addr 0x0.
  - id_pc_o/id_inst_o then read 0x0, 0x4, 0x8 on consecutive cycles.
- 2 wait states on addr 0x8, stall_i=0:
  - fetch_stall_o=1 for 2 cycles.
  - id_inst_o=0 (bubble) for 2 cycles, then id_pc_o=0x8.
  - imem_addr_o holds 0x8 throughout.
- Ack at 0xC while stall_i=1 for 3 cycles:
  - imem_req_o=0 during hold; id_pc_o unchanged.
  - On release, id_pc_o=0xC and the next request is 0x10.
- Zero-wait, branch at 0x10 with branch_flag_i=1 and target 0x100 while 0x14 is fetched:
  - id_pc_o sequence 0x10, 0x14, 0x100.
- Same branch, but 0x14 takes 3 wait states with stall_i=0:
  - br_pend=1; bubbles are inserted.
  - id_pc_o=0x14 then 0x100.
- rst pulsed mid-cycle while req=1 and a wait state is in progress:
  - All outputs zero immediately (asynchronously); refetch from RESET_PC.
  - With IF_MISALIGN_CHECK_EN defined, a branch to 0x102 gives inst_misalign_o=1 with id_pc_o=0x102 and no request issued.
